// File: rtl/bcpu_thread_scheduler.sv
// -----------------------------------------------------------------------------
// bcpu_thread_scheduler
// Barrel thread scheduler for the BCPU16 core. It holds a PC and a run/pend
// pair for each thread and issues one thread slot per cycle in round-robin
// order. Write-back results steer each thread's next PC: a jump target, a
// replay of the same PC, or PC+1. Start and stop requests launch and halt
// threads.
//
// Optional feature: define BCPU_SCHED_PERF_COUNTERS_EN to add the
// PERF_ISSUED / PERF_IDLE slot counters.
// -----------------------------------------------------------------------------
module bcpu_thread_scheduler #(
  parameter int                   PC_WIDTH    = 10,
  parameter int                   THREAD_BITS = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        CE,
  output logic                        ISSUE_VALID,
  output logic [THREAD_BITS-1:0]      ISSUE_THREAD,
  output logic [PC_WIDTH-1:0]         ISSUE_PC,
  input  logic                        WB_VALID,
  input  logic [THREAD_BITS-1:0]      WB_THREAD,
  input  logic                        WB_JMP_EN,
  input  logic [PC_WIDTH-1:0]         WB_JMP_ADDR,
  input  logic                        WB_REPLAY,
  input  logic                        START_EN,
  input  logic [THREAD_BITS-1:0]      START_THREAD,
  input  logic [PC_WIDTH-1:0]         START_PC,
  input  logic                        STOP_EN,
  input  logic [THREAD_BITS-1:0]      STOP_THREAD,
  output logic [2**THREAD_BITS-1:0]   THREAD_RUN,
  output logic [2**THREAD_BITS-1:0]   THREAD_PEND
`ifdef BCPU_SCHED_PERF_COUNTERS_EN
  ,
  output logic [31:0]                 PERF_ISSUED,
  output logic [31:0]                 PERF_IDLE
`endif
);

  localparam int NUM_THREADS = 2**THREAD_BITS;

  // Per-thread state is the {run, pend} pair.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_BUSY  = 2'b11;
  localparam logic [1:0] ST_DRAIN = 2'b01;

  logic [THREAD_BITS-1:0] slot_q, slot_d;
  logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] run_q, run_d;
  logic [NUM_THREADS-1:0] pend_q, pend_d;
  logic [NUM_THREADS-1:0] wb_hit, stop_hit, start_ok;
  logic                   issue_now;

  logic                   issue_valid_q;
  logic [THREAD_BITS-1:0] issue_thread_q;
  logic [PC_WIDTH-1:0]    issue_pc_q;

  // Next-state for slot, per-thread PC and run/pend, all from pre-edge state.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    slot_d    = slot_q + THREAD_BITS'(1);
    issue_now = run_q[slot_q] & ~pend_q[slot_q];
    wb_hit    = '0;
    stop_hit  = '0;
    start_ok  = '0;
    run_d     = run_q;
    pend_d    = pend_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      pc_d[t] = pc_q[t];

      // A write-back only counts for a thread that has an instruction in flight.
      wb_hit[t]   = WB_VALID && (WB_THREAD == THREAD_BITS'(t)) && pend_q[t];
      stop_hit[t] = STOP_EN && (STOP_THREAD == THREAD_BITS'(t));
      // Start needs a fully idle thread and loses to a simultaneous stop.
      start_ok[t] = START_EN && (START_THREAD == THREAD_BITS'(t)) &&
                    ({run_q[t], pend_q[t]} == ST_IDLE) && !stop_hit[t];

      if (wb_hit[t]) begin
        if (WB_JMP_EN)       pc_d[t] = WB_JMP_ADDR;
        else if (!WB_REPLAY) pc_d[t] = pc_q[t] + PC_WIDTH'(1);
      end
      if (start_ok[t]) pc_d[t] = START_PC;

      if (stop_hit[t])      run_d[t] = 1'b0;
      else if (start_ok[t]) run_d[t] = 1'b1;

      // Issue and write-back cannot collide: issue needs pend=0, write-back pend=1.
      if (issue_now && (slot_q == THREAD_BITS'(t))) pend_d[t] = 1'b1;
      else if (wb_hit[t])                           pend_d[t] = 1'b0;
    end
  end

  // State and issue registers; everything holds while CE is low.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_q         <= '0;
      run_q          <= NUM_THREADS'(1);
      pend_q         <= '0;
      issue_valid_q  <= 1'b0;
      issue_thread_q <= '0;
      issue_pc_q     <= '0;
      // NOTE: the PC file is a handful of flops, not a RAM, so resetting it is cheap and required.
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RESET_PC;
    end else if (CE) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      slot_q         <= slot_d;
      run_q          <= run_d;
      pend_q         <= pend_d;
      issue_valid_q  <= issue_now;
      issue_thread_q <= slot_q;
      issue_pc_q     <= pc_q[slot_q];
      for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= pc_d[t];
    end
  end

  assign ISSUE_VALID  = issue_valid_q;
  assign ISSUE_THREAD = issue_thread_q;
  assign ISSUE_PC     = issue_pc_q;
  assign THREAD_RUN   = run_q;
  assign THREAD_PEND  = pend_q;

`ifdef BCPU_SCHED_PERF_COUNTERS_EN
  logic [31:0] perf_issued_q, perf_idle_q;

  // Exactly one counter advances per enabled cycle, keyed on the issue decision.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      perf_issued_q <= '0;
      perf_idle_q   <= '0;
    end else if (CE) begin
      if (issue_now) perf_issued_q <= perf_issued_q + 32'd1;
      else           perf_idle_q   <= perf_idle_q + 32'd1;
    end
  end

  assign PERF_ISSUED = perf_issued_q;
  assign PERF_IDLE   = perf_idle_q;
`endif

endmodule

// File: tb/tb_bcpu_thread_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bcpu_thread_scheduler
// Directed bench for the barrel thread scheduler: round-robin issue, jump and
// wrap, replay, stop/drain, start/stop collision, async reset and clock enable.
// The perf-counter section is built only with BCPU_SCHED_PERF_COUNTERS_EN.
// -----------------------------------------------------------------------------
module tb_bcpu_thread_scheduler;

  logic        CLK;
  logic        RESET_N;
  logic        CE;
  logic        ISSUE_VALID;
  logic [1:0]  ISSUE_THREAD;
  logic [9:0]  ISSUE_PC;
  logic        WB_VALID;
  logic [1:0]  WB_THREAD;
  logic        WB_JMP_EN;
  logic [9:0]  WB_JMP_ADDR;
  logic        WB_REPLAY;
  logic        START_EN;
  logic [1:0]  START_THREAD;
  logic [9:0]  START_PC;
  logic        STOP_EN;
  logic [1:0]  STOP_THREAD;
  logic [3:0]  THREAD_RUN;
  logic [3:0]  THREAD_PEND;
`ifdef BCPU_SCHED_PERF_COUNTERS_EN
  logic [31:0] PERF_ISSUED;
  logic [31:0] PERF_IDLE;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bcpu_thread_scheduler #(
    .PC_WIDTH    (10),
    .THREAD_BITS (2),
    .RESET_PC    (10'd0)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .CE           (CE),
    .ISSUE_VALID  (ISSUE_VALID),
    .ISSUE_THREAD (ISSUE_THREAD),
    .ISSUE_PC     (ISSUE_PC),
    .WB_VALID     (WB_VALID),
    .WB_THREAD    (WB_THREAD),
    .WB_JMP_EN    (WB_JMP_EN),
    .WB_JMP_ADDR  (WB_JMP_ADDR),
    .WB_REPLAY    (WB_REPLAY),
    .START_EN     (START_EN),
    .START_THREAD (START_THREAD),
    .START_PC     (START_PC),
    .STOP_EN      (STOP_EN),
    .STOP_THREAD  (STOP_THREAD),
    .THREAD_RUN   (THREAD_RUN),
    .THREAD_PEND  (THREAD_PEND)
`ifdef BCPU_SCHED_PERF_COUNTERS_EN
    ,
    .PERF_ISSUED  (PERF_ISSUED),
    .PERF_IDLE    (PERF_IDLE)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wb_set(input logic [1:0] thr, input logic jmp, input logic [9:0] addr,
                        input logic rep);
    WB_VALID = 1'b1; WB_THREAD = thr; WB_JMP_EN = jmp; WB_JMP_ADDR = addr; WB_REPLAY = rep;
  endtask

  task automatic wb_clear();
    WB_VALID = 1'b0; WB_THREAD = '0; WB_JMP_EN = 1'b0; WB_JMP_ADDR = '0; WB_REPLAY = 1'b0;
  endtask

  task automatic start_set(input logic [1:0] thr, input logic [9:0] pc);
    START_EN = 1'b1; START_THREAD = thr; START_PC = pc;
  endtask

  task automatic start_clear();
    START_EN = 1'b0; START_THREAD = '0; START_PC = '0;
  endtask

  task automatic stop_set(input logic [1:0] thr);
    STOP_EN = 1'b1; STOP_THREAD = thr;
  endtask

  task automatic stop_clear();
    STOP_EN = 1'b0; STOP_THREAD = '0;
  endtask

  // Hold reset for two edges, release 1 ns after an edge; the next edge is "edge 1".
  task automatic do_reset();
    RESET_N = 1'b0;
    CE = 1'b1;
    wb_clear();
    start_clear();
    stop_clear();
    tick(2);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0;
    CE = 1'b1;
    wb_clear();
    start_clear();
    stop_clear();

    // ---- Reset state, then thread 0 alone with write-back two cycles after issue
    do_reset();
    check("rst_valid",  ISSUE_VALID,  0);
    check("rst_thread", ISSUE_THREAD, 0);
    check("rst_pc",     ISSUE_PC,     0);
    check("rst_run",    THREAD_RUN,   4'b0001);
    check("rst_pend",   THREAD_PEND,  4'b0000);
    tick();                                           // edge 1: thread 0, PC 0
    check("a_e1_valid", ISSUE_VALID, 1);
    check("a_e1_pc",    ISSUE_PC,    0);
    check("a_e1_pend",  THREAD_PEND, 4'b0001);
    tick();                                           // edge 2: thread 1 idle
    check("a_e2_thread", ISSUE_THREAD, 1);
    check("a_e2_valid",  ISSUE_VALID,  0);
    wb_set(2'd0, 1'b0, 10'd0, 1'b0);
    tick();                                           // edge 3: WB for thread 0
    wb_clear();
    check("a_e3_valid", ISSUE_VALID, 0);
    check("a_e3_pend",  THREAD_PEND, 4'b0000);
    tick();                                           // edge 4: thread 3 idle
    check("a_e4_thread", ISSUE_THREAD, 3);
    check("a_e4_valid",  ISSUE_VALID,  0);
    tick();                                           // edge 5: thread 0, PC 1
    check("a_e5_thread", ISSUE_THREAD, 0);
    check("a_e5_valid",  ISSUE_VALID,  1);
    check("a_e5_pc",     ISSUE_PC,     1);
    tick();
    wb_set(2'd0, 1'b0, 10'd0, 1'b0);
    tick();                                           // edge 7: WB
    wb_clear();
    tick(2);                                          // edge 9: thread 0, PC 2
    check("a_e9_valid", ISSUE_VALID, 1);
    check("a_e9_pc",    ISSUE_PC,    2);

    // ---- Start thread 2 at 0x100, jump to 0x3FF, then wrap to 0x000
    do_reset();
    start_set(2'd2, 10'h100);
    tick();                                           // edge 1: start accepted
    start_clear();
    check("b_run", THREAD_RUN, 4'b0101);
    tick(2);                                          // edge 3: thread 2, 0x100
    check("b_e3_thread", ISSUE_THREAD, 2);
    check("b_e3_valid",  ISSUE_VALID,  1);
    check("b_e3_pc",     ISSUE_PC,     10'h100);
    tick();
    wb_set(2'd2, 1'b1, 10'h3FF, 1'b0);
    tick();                                           // edge 5: thread 0 still busy, skips
    wb_clear();
    check("b_e5_t0_skip", ISSUE_VALID, 0);
    tick(2);                                          // edge 7: thread 2, 0x3FF
    check("b_e7_valid", ISSUE_VALID, 1);
    check("b_e7_pc",    ISSUE_PC,    10'h3FF);
    tick();
    wb_set(2'd2, 1'b0, 10'h155, 1'b0);
    tick();                                           // edge 9: plain WB
    wb_clear();
    tick(2);                                          // edge 11: thread 2, wrapped
    check("b_e11_valid", ISSUE_VALID, 1);
    check("b_e11_pc",    ISSUE_PC,    10'h000);

    // ---- Thread 1 replays three times, then advances
    do_reset();
    start_set(2'd1, 10'h010);
    tick();                                           // edge 1
    start_clear();
    for (int i = 0; i < 5; i++) begin
      tick();                                         // edge 2 + 4*i: thread 1 issues
      check("c_thread", ISSUE_THREAD, 1);
      check("c_valid",  ISSUE_VALID,  1);
      check("c_pc",     ISSUE_PC,     (i < 4) ? 10'h010 : 10'h011);
      if (i < 4) begin
        tick();
        wb_set(2'd1, 1'b0, 10'h2AA, (i < 3));
        tick();
        wb_clear();
        tick();
      end
    end

    // ---- Stop thread 0 while busy; drain, ignored start, later start
    do_reset();
    tick();                                           // edge 1: thread 0 issued
    stop_set(2'd0);
    tick();                                           // edge 2: stop -> DRAIN
    stop_clear();
    check("d_drain_run",  THREAD_RUN,  4'b0000);
    check("d_drain_pend", THREAD_PEND, 4'b0001);
    wb_set(2'd0, 1'b1, 10'h020, 1'b0);
    start_set(2'd0, 10'h040);
    tick();                                           // edge 3: WB lands, start ignored
    wb_clear();
    start_clear();
    check("d_idle_run",  THREAD_RUN,  4'b0000);
    check("d_idle_pend", THREAD_PEND, 4'b0000);
    tick(2);                                          // edge 5: slot 0, no issue
    check("d_e5_thread", ISSUE_THREAD, 0);
    check("d_e5_valid",  ISSUE_VALID,  0);
    check("d_e5_pc",     ISSUE_PC,     10'h020);
    start_set(2'd0, 10'h040);
    tick();                                           // edge 6: start accepted
    start_clear();
    check("d_restart_run", THREAD_RUN, 4'b0001);
    tick(3);                                          // edge 9: thread 0, 0x40
    check("d_e9_valid", ISSUE_VALID, 1);
    check("d_e9_pc",    ISSUE_PC,    10'h040);

    // ---- Start and stop thread 3 together; then async reset mid-run
    do_reset();
    start_set(2'd3, 10'h055);
    stop_set(2'd3);
    tick();                                           // edge 1
    start_clear();
    stop_clear();
    check("e_run", THREAD_RUN, 4'b0001);
    tick(3);                                          // edge 4: slot 3
    check("e_e4_thread", ISSUE_THREAD, 3);
    check("e_e4_valid",  ISSUE_VALID,  0);
    check("e_e4_pend",   THREAD_PEND,  4'b0001);
    #2;
    RESET_N = 1'b0;
    #1;
    check("e_arst_valid",  ISSUE_VALID,  0);
    check("e_arst_thread", ISSUE_THREAD, 0);
    check("e_arst_pc",     ISSUE_PC,     0);
    check("e_arst_run",    THREAD_RUN,   4'b0001);
    check("e_arst_pend",   THREAD_PEND,  4'b0000);

    // ---- CE low for five cycles freezes everything
    do_reset();
    tick(2);                                          // edge 2: slot 1 shown
    CE = 1'b0;
    wb_set(2'd0, 1'b0, 10'd0, 1'b0);
    start_set(2'd1, 10'h077);
    tick(5);
    check("f_hold_thread", ISSUE_THREAD, 1);
    check("f_hold_valid",  ISSUE_VALID,  0);
    check("f_hold_pc",     ISSUE_PC,     0);
    check("f_hold_run",    THREAD_RUN,   4'b0001);
    check("f_hold_pend",   THREAD_PEND,  4'b0001);
    CE = 1'b1;
    wb_clear();
    start_clear();
    tick();                                           // slot resumes at 2
    check("f_resume_thread", ISSUE_THREAD, 2);
    check("f_resume_pend",   THREAD_PEND,  4'b0001);
    check("f_resume_run",    THREAD_RUN,   4'b0001);

`ifdef BCPU_SCHED_PERF_COUNTERS_EN
    // ---- Perf counters: one increment per enabled cycle
    do_reset();
    check("g_rst_issued", PERF_ISSUED, 0);
    check("g_rst_idle",   PERF_IDLE,   0);
    tick(100);
    check("g_sum",    PERF_ISSUED + PERF_IDLE, 100);
    check("g_issued", PERF_ISSUED, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
